// File: rtl/noc_rr_arbiter_nto1_if.sv
// Handshake bundle for the N-to-1 round-robin arbiter: per-input four-phase
// req/ack with packet data, the shared output channel, and status.
interface noc_rr_arbiter_nto1_if #(
    parameter int WIDTH_packet = 57,
    parameter int NUM_IN       = 4
);
    localparam int GID_W = $clog2(NUM_IN);

    logic [NUM_IN-1:0]              in_req;
    logic [NUM_IN-1:0]              in_ack;
    logic [NUM_IN*WIDTH_packet-1:0] in_data;
    logic                           out_req;
    logic                           out_ack;
    logic [WIDTH_packet-1:0]        out_data;
    logic                           busy;
    logic [GID_W-1:0]               grant_id;

    // master: the arbiter itself
    modport master (
        input  in_req, in_data, out_ack,
        output in_ack, out_req, out_data, busy, grant_id
    );

    // slave: the input ports and output link surrounding the arbiter
    modport slave (
        output in_req, in_data, out_ack,
        input  in_ack, out_req, out_data, busy, grant_id
    );
endinterface

// File: rtl/noc_rr_arbiter_nto1.sv
// N-to-1 round-robin arbiter for a NoC output port: four-phase handshakes on
// both sides with a single-packet buffer between input and output transfers.
module noc_rr_arbiter_nto1 #(
    parameter int WIDTH_packet = 57,
    parameter int NUM_IN       = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    noc_rr_arbiter_nto1_if.master   arb
);
    localparam int IDX_W = $clog2(NUM_IN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2,
        RET   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        gid_q, gid_d;
    logic [NUM_IN-1:0]       ack_q, ack_d;
    logic                    oreq_q, oreq_d;
    logic [WIDTH_packet-1:0] out_q, out_d;
    logic [WIDTH_packet-1:0] pkt_buf_q;
    logic [WIDTH_packet-1:0] sel_data;
    logic [IDX_W-1:0]        winner;
    logic                    any_req;
    logic                    capture;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) == NUM_IN - 1)
            return '0;
        else
            return idx + 1'b1;
    endfunction

    // Scan ptr, ptr+1, ... with wrap; the first requester found wins.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_IN-1:0] req,
                                                 input logic [IDX_W-1:0]  start);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pick;
        logic             found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return pick;
    endfunction

    assign any_req  = |arb.in_req;
    assign winner   = rr_pick(arb.in_req, ptr_q);
    assign sel_data = arb.in_data[winner*WIDTH_packet +: WIDTH_packet];
    assign capture  = (state_q == IDLE) && any_req;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        ack_d   = ack_q;
        oreq_d  = oreq_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    ack_d   = NUM_IN'(1) << winner;
                    gid_d   = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // The grant is committed: only the winner's req is watched.
                if (!arb.in_req[gid_q]) begin
                    ack_d   = '0;
                    out_d   = pkt_buf_q;
                    oreq_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Priority moves only once the output has taken the packet.
                if (arb.out_ack) begin
                    oreq_d  = 1'b0;
                    ptr_d   = next_idx(gid_q);
                    state_d = RET;
                end
            end
            RET: begin
                if (!arb.out_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            ack_q   <= '0;
            oreq_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            oreq_q  <= oreq_d;
            out_q   <= out_d;
        end
    end

    // Packet buffer is pure data; it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (capture)
            pkt_buf_q <= sel_data;
    end

    assign arb.in_ack   = ack_q;
    assign arb.out_req  = oreq_q;
    assign arb.out_data = out_q;
    assign arb.busy     = (state_q != IDLE);
    assign arb.grant_id = gid_q;

endmodule

// File: tb/tb_noc_rr_arbiter_nto1.sv
// Bench for noc_rr_arbiter_nto1: directed vector table, corner sequences and
// randomized traffic checked against a transaction-level reference.
module tb_noc_rr_arbiter_nto1;
    localparam int W = 57;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    noc_rr_arbiter_nto1_if #(.WIDTH_packet(W), .NUM_IN(N)) bus ();

    noc_rr_arbiter_nto1 #(.WIDTH_packet(W), .NUM_IN(N)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         rst;
        logic [3:0]   req;
        logic         oack;
        logic [3:0]   ack;
        logic         oreq;
        logic [1:0]   gid;
        logic         busy;
        logic [W-1:0] data;
    } vec_t;

    vec_t         tbl [18];
    logic [W-1:0] d [N];

    // Reference state for the randomized phase
    int           m_stage;
    int           m_ptr;
    int           m_gid;
    logic [3:0]   m_ack;
    logic         m_oreq;
    logic [W-1:0] m_out;
    logic [W-1:0] m_buf;
    int           waitc [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic oa);
        @(negedge clk);
        bus.in_req  = r;
        bus.out_ack = oa;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ack"},   64'(bus.in_ack),   64'd0);
        chk({tag, "_out_req"},  64'(bus.out_req),  64'd0);
        chk({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
        chk({tag, "_busy"},     64'(bus.busy),     64'd0);
        chk({tag, "_grant_id"}, 64'(bus.grant_id), 64'd0);
    endtask

    function automatic logic [W-1:0] rand_pkt();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    task automatic model_reset();
        m_stage = 0; m_ptr = 0; m_gid = 0;
        m_ack = '0; m_oreq = 1'b0; m_out = '0; m_buf = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
    endtask

    // Advance the reference by one clock using the inputs the DUT just sampled.
    task automatic model_step();
        logic [3:0] r;
        int w;
        r = bus.in_req;
        for (int i = 0; i < N; i++) if (!r[i]) waitc[i] = 0;
        case (m_stage)
            0: if (r != 4'd0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                chk("rnd_fairness", 64'(waitc[w] <= N), 64'd1);
                waitc[w] = 0;
                m_buf   = bus.in_data[w*W +: W];
                m_ack   = 4'b0001 << w;
                m_gid   = w;
                m_stage = 1;
            end
            1: if (!r[m_gid]) begin
                m_ack = '0; m_out = m_buf; m_oreq = 1'b1; m_stage = 2;
            end
            2: if (bus.out_ack) begin
                m_oreq = 1'b0;
                m_ptr  = (m_gid + 1) % N;
                for (int i = 0; i < N; i++) if (r[i] && i != m_gid) waitc[i]++;
                m_stage = 3;
            end
            3: if (!bus.out_ack) m_stage = 0;
            default: m_stage = 0;
        endcase
    endtask

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (!bus.in_req[i] && !bus.in_ack[i]) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.in_data[i*W +: W] = rand_pkt();
                    bus.in_req[i] = 1'b1;
                end
            end else if (bus.in_req[i] && bus.in_ack[i]) begin
                if ($urandom_range(0, 1) == 0) bus.in_req[i] = 1'b0;
            end else if (bus.in_req[i] && !bus.in_ack[i]) begin
                if ($urandom_range(0, 31) == 0) bus.in_req[i] = 1'b0;
            end
        end
        if (bus.out_req && !bus.out_ack && $urandom_range(0, 1) == 0) bus.out_ack = 1'b1;
        else if (!bus.out_req && bus.out_ack && $urandom_range(0, 1) == 0) bus.out_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [6];
        int ngrant;
        int last_w;
        logic [3:0] prev_ack;
        logic prev_oreq;

        d[0] = 57'h1_0000_0000_0A00;
        d[1] = 57'h0_1234_5678_9ABC;
        d[2] = 57'h1_FFFF_0000_0002;
        d[3] = 57'h0_0000_FFFF_3333;
        bus.in_req  = '0;
        bus.out_ack = 1'b0;
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = d[i];

        // rst req oack | ack oreq gid busy data
        tbl[0]  = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd1, 1'b1, 57'd0};
        tbl[1]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, d[1]};
        tbl[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, d[1]};
        tbl[3]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, d[1]};
        tbl[4]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 57'd0};
        tbl[5]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 57'd0};
        tbl[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, d[0]};
        tbl[7]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, d[0]};
        tbl[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, d[0]};
        tbl[9]  = '{1'b0, 4'b0101, 1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, d[0]};
        tbl[10] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, d[2]};
        tbl[11] = '{1'b0, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, d[2]};
        tbl[12] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, d[2]};
        tbl[13] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, d[2]};
        tbl[14] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, d[0]};
        tbl[15] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, d[0]};
        tbl[16] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, d[0]};
        tbl[17] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, d[0]};

        #1;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            reset       = tbl[k].rst;
            bus.in_req  = tbl[k].req;
            bus.out_ack = tbl[k].oack;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_in_ack", k),   64'(bus.in_ack),   64'(tbl[k].ack));
            chk($sformatf("tbl%0d_out_req", k),  64'(bus.out_req),  64'(tbl[k].oreq));
            chk($sformatf("tbl%0d_grant_id", k), 64'(bus.grant_id), 64'(tbl[k].gid));
            chk($sformatf("tbl%0d_busy", k),     64'(bus.busy),     64'(tbl[k].busy));
            chk($sformatf("tbl%0d_out_data", k), 64'(bus.out_data), 64'(tbl[k].data));
        end

        // Output stall: ptr is 1, input 3 is the sole requester
        cyc(4'b1000, 1'b0);
        chk("stall_grant", 64'(bus.in_ack), 64'b1000);
        cyc(4'b0111, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cyc(4'b0111, 1'b0);
            chk("stall_out_req",  64'(bus.out_req),  64'd1);
            chk("stall_out_data", 64'(bus.out_data), 64'(d[3]));
            chk("stall_in_ack",   64'(bus.in_ack),   64'd0);
        end
        cyc(4'b0111, 1'b1);
        chk("stall_release", 64'(bus.out_req), 64'd0);
        cyc(4'b0111, 1'b0);
        cyc(4'b0111, 1'b0);
        chk("stall_next_ack", 64'(bus.in_ack),   64'b0001);
        chk("stall_next_gid", 64'(bus.grant_id), 64'd0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b0);

        // Reset pulsed mid-SEND, then inputs 3 and 0 compete
        cyc(4'b0100, 1'b0);
        chk("midrst_grant", 64'(bus.in_ack), 64'b0100);
        cyc(4'b0000, 1'b0);
        chk("midrst_send", 64'(bus.out_req), 64'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_vals("midrst");
        bus.in_req = 4'b1001;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_first_ack", 64'(bus.in_ack),   64'b0001);
        chk("midrst_first_gid", 64'(bus.grant_id), 64'd0);
        cyc(4'b1000, 1'b0);
        chk("midrst_data", 64'(bus.out_data), 64'(d[0]));
        cyc(4'b1000, 1'b1);
        cyc(4'b1000, 1'b0);
        cyc(4'b0000, 1'b0);

        // All inputs requesting from reset with ideal partners
        @(negedge clk);
        reset = 1'b1;
        bus.in_req  = 4'b1111;
        bus.out_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_order = '{0, 1, 2, 3, 0, 1};
        ngrant = 0;
        last_w = 0;
        prev_ack = '0;
        prev_oreq = 1'b0;
        for (int c = 0; c < 60 && ngrant < 6; c++) begin
            @(posedge clk);
            #1;
            if (prev_ack == 4'd0 && bus.in_ack != 4'd0) begin
                chk($sformatf("order%0d", ngrant), 64'(bus.in_ack), 64'(4'b0001 << exp_order[ngrant]));
                last_w = exp_order[ngrant];
                ngrant++;
            end
            if (!prev_oreq && bus.out_req)
                chk("order_data", 64'(bus.out_data), 64'(d[last_w]));
            prev_ack  = bus.in_ack;
            prev_oreq = bus.out_req;
            @(negedge clk);
            bus.in_req  = ~bus.in_ack;
            bus.out_ack = bus.out_req;
        end
        chk("order_count", 64'(ngrant), 64'd6);

        // Randomized traffic against the reference
        @(negedge clk);
        reset = 1'b1;
        bus.in_req  = '0;
        bus.out_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            model_step();
            chk("rnd_in_ack",   64'(bus.in_ack),   64'(m_ack));
            chk("rnd_out_req",  64'(bus.out_req),  64'(m_oreq));
            chk("rnd_out_data", 64'(bus.out_data), 64'(m_out));
            chk("rnd_grant_id", 64'(bus.grant_id), 64'(m_gid));
            chk("rnd_busy",     64'(bus.busy),     64'(m_stage != 0));
            chk("rnd_onehot",   64'($countones(bus.in_ack) <= 1), 64'd1);
            chk("rnd_excl",     64'(bus.out_req && (bus.in_ack != 4'd0)), 64'd0);
            if (c == 1000) begin
                #2 reset = 1'b1;
                #1 chk_reset_vals("rnd_reset");
                @(negedge clk);
                reset = 1'b0;
                model_reset();
            end
            drive_random();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
